// File: rtl/nn_product_accumulator.sv
`default_nettype none
// ============================================================================
// nn_product_accumulator
//   Sums a programmed number of unsigned products into one saturating sum.
//   Revision: 1.0
// ============================================================================
module nn_product_accumulator #(
  parameter int PROD_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  input  logic                  s_prod_valid,
  output logic                  s_prod_ready,
  input  logic [PROD_WIDTH-1:0] s_prod_data,
  output logic                  m_sum_valid,
  input  logic                  m_sum_ready,
  output logic [ACC_WIDTH-1:0]  m_sum_data,
  output logic                  m_sum_ovf
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_WIDTH:0]   sum_ext;
  logic [LEN_WIDTH-1:0] last_cnt;

  // One extra bit catches the carry out that signals saturation.
  assign sum_ext  = {1'b0, acc_q} + (ACC_WIDTH+1)'(s_prod_data);
  assign last_cnt = len_q - LEN_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = len;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = (len == '0) ? ST_OUT : ST_ACC;
        end
      end
      ST_ACC: begin
        if (s_prod_valid) begin
          if (sum_ext[ACC_WIDTH]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum_ext[ACC_WIDTH-1:0];
          end
          cnt_d = cnt_q + LEN_WIDTH'(1);
          if (cnt_q == last_cnt) begin
            state_d = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (m_sum_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign s_prod_ready = (state_q == ST_ACC);
  assign m_sum_valid  = (state_q == ST_OUT);
  assign m_sum_data   = acc_q;
  assign m_sum_ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nn_product_accumulator.sv
`default_nettype none
// ============================================================================
// tb_nn_product_accumulator
//   Directed bench: 32-bit instance for most runs, 17-bit instance for saturation.
//   Revision: 1.0
// ============================================================================
module tb_nn_product_accumulator;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;

  logic        a_start = 1'b0;
  logic [15:0] a_len = '0;
  logic        a_busy;
  logic        a_pvalid = 1'b0;
  logic        a_pready;
  logic [15:0] a_pdata = '0;
  logic        a_svalid;
  logic        a_sready = 1'b0;
  logic [31:0] a_sdata;
  logic        a_sovf;

  logic        b_start = 1'b0;
  logic [15:0] b_len = '0;
  logic        b_busy;
  logic        b_pvalid = 1'b0;
  logic        b_pready;
  logic [15:0] b_pdata = '0;
  logic        b_svalid;
  logic        b_sready = 1'b0;
  logic [16:0] b_sdata;
  logic        b_sovf;

  int total = 0;
  int bad   = 0;

  always #5 ap_clk = ~ap_clk;

  nn_product_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(32), .LEN_WIDTH(16)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(a_start), .len(a_len), .busy(a_busy),
    .s_prod_valid(a_pvalid), .s_prod_ready(a_pready), .s_prod_data(a_pdata),
    .m_sum_valid(a_svalid), .m_sum_ready(a_sready), .m_sum_data(a_sdata), .m_sum_ovf(a_sovf)
  );

  nn_product_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(17), .LEN_WIDTH(16)) dut17 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(b_start), .len(b_len), .busy(b_busy),
    .s_prod_valid(b_pvalid), .s_prod_ready(b_pready), .s_prod_data(b_pdata),
    .m_sum_valid(b_svalid), .m_sum_ready(b_sready), .m_sum_data(b_sdata), .m_sum_ovf(b_sovf)
  );

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [15:0] d);
    int n = 0;
    a_pvalid = 1'b1;
    a_pdata  = d;
    while (!a_pready && n < 20) begin
      step();
      n++;
    end
    chk("a_ready_wait", 64'(n < 20), 64'd1);
    step();
    a_pvalid = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] d);
    int n = 0;
    b_pvalid = 1'b1;
    b_pdata  = d;
    while (!b_pready && n < 20) begin
      step();
      n++;
    end
    chk("b_ready_wait", 64'(n < 20), 64'd1);
    step();
    b_pvalid = 1'b0;
  endtask

  task automatic start_a(input logic [15:0] l);
    a_start = 1'b1;
    a_len   = l;
    step();
    a_start = 1'b0;
  endtask

  task automatic start_b(input logic [15:0] l);
    b_start = 1'b1;
    b_len   = l;
    step();
    b_start = 1'b0;
  endtask

  task automatic take_a();
    a_sready = 1'b1;
    step();
    a_sready = 1'b0;
  endtask

  task automatic take_b();
    b_sready = 1'b1;
    step();
    b_sready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step();
    step();
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_pready", 64'(a_pready), 64'd0);
    chk("rst_svalid", 64'(a_svalid), 64'd0);
    chk("rst_sdata", 64'(a_sdata), 64'd0);
    chk("rst_sovf", 64'(a_sovf), 64'd0);
    ap_rst_n = 1'b1;
    step();

    // T1 basic
    start_a(16'd4);
    chk("t1_busy", 64'(a_busy), 64'd1);
    chk("t1_pready", 64'(a_pready), 64'd1);
    chk("t1_svalid_early", 64'(a_svalid), 64'd0);
    send_a(16'd1);
    send_a(16'd2);
    send_a(16'd3);
    chk("t1_svalid_before_last", 64'(a_svalid), 64'd0);
    send_a(16'd4);
    chk("t1_svalid", 64'(a_svalid), 64'd1);
    chk("t1_sdata", 64'(a_sdata), 64'd10);
    chk("t1_sovf", 64'(a_sovf), 64'd0);
    chk("t1_pready_out", 64'(a_pready), 64'd0);
    take_a();
    chk("t1_idle_valid", 64'(a_svalid), 64'd0);
    chk("t1_idle_busy", 64'(a_busy), 64'd0);

    // T2 zero length
    a_pvalid = 1'b1;
    a_pdata  = 16'h00AA;
    start_a(16'd0);
    chk("t2_svalid", 64'(a_svalid), 64'd1);
    chk("t2_sdata", 64'(a_sdata), 64'd0);
    chk("t2_sovf", 64'(a_sovf), 64'd0);
    chk("t2_pready", 64'(a_pready), 64'd0);
    a_pvalid = 1'b0;
    take_a();
    chk("t2_idle_busy", 64'(a_busy), 64'd0);

    // T3 gaps and backpressure
    start_a(16'd3);
    send_a(16'hFFFF);
    step();
    step();
    send_a(16'h0001);
    step();
    send_a(16'h0100);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 64'(a_svalid), 64'd1);
      chk("t3_hold_data", 64'(a_sdata), 64'h10100);
      step();
    end
    chk("t3_sovf", 64'(a_sovf), 64'd0);
    take_a();
    chk("t3_idle_valid", 64'(a_svalid), 64'd0);
    chk("t3_idle_busy", 64'(a_busy), 64'd0);

    // T4 saturation on the 17-bit instance
    start_b(16'd3);
    send_b(16'hFFFF);
    send_b(16'hFFFF);
    chk("t4_no_sat_yet", 64'(b_sovf), 64'd0);
    chk("t4_partial", 64'(b_sdata), 64'h1FFFE);
    send_b(16'hFFFF);
    chk("t4_svalid", 64'(b_svalid), 64'd1);
    chk("t4_sdata", 64'(b_sdata), 64'h1FFFF);
    chk("t4_sovf", 64'(b_sovf), 64'd1);
    take_b();
    step();
    start_b(16'd1);
    chk("t4_ovf_cleared", 64'(b_sovf), 64'd0);
    send_b(16'd5);
    chk("t4b_svalid", 64'(b_svalid), 64'd1);
    chk("t4b_sdata", 64'(b_sdata), 64'd5);
    chk("t4b_sovf", 64'(b_sovf), 64'd0);
    take_b();

    // T5 reset mid-run
    start_a(16'd8);
    send_a(16'd1);
    send_a(16'd2);
    send_a(16'd3);
    ap_rst_n = 1'b0;
    step();
    chk("t5_busy", 64'(a_busy), 64'd0);
    chk("t5_pready", 64'(a_pready), 64'd0);
    chk("t5_svalid", 64'(a_svalid), 64'd0);
    chk("t5_sdata", 64'(a_sdata), 64'd0);
    chk("t5_sovf", 64'(a_sovf), 64'd0);
    ap_rst_n = 1'b1;
    step();
    start_a(16'd2);
    send_a(16'd7);
    send_a(16'd8);
    chk("t5b_svalid", 64'(a_svalid), 64'd1);
    chk("t5b_sdata", 64'(a_sdata), 64'd15);
    take_a();

    // T6 start while busy
    step();
    start_a(16'd2);
    send_a(16'd1);
    a_start = 1'b1;
    a_len   = 16'd9;
    send_a(16'd1);
    a_start = 1'b0;
    chk("t6_svalid", 64'(a_svalid), 64'd1);
    chk("t6_sdata", 64'(a_sdata), 64'd2);
    take_a();
    step();
    step();
    chk("t6_no_spurious_busy", 64'(a_busy), 64'd0);
    chk("t6_no_spurious_valid", 64'(a_svalid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
